// File: rtl/ultrasonic_ping_gen.sv
// Ultrasonic ping transmitter: drives the sensor trigger pulse, runs the ping timer,
// reports the first echo rising edge (done) or timer exhaustion (timeout), then holds off.
module ultrasonic_ping_gen #(
  parameter int unsigned TIMER_W        = 13,
  parameter int unsigned TRIG_CYCLES    = 500,
  parameter int unsigned HOLDOFF_CYCLES = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               echo,
  output logic               trig,
  output logic [TIMER_W-1:0] timer,
  output logic               busy,
  output logic               done,
  output logic               timeout
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_TRIG,
    S_LISTEN,
    S_HOLDOFF
  } state_t;

  localparam logic [15:0]        TRIG_LAST = 16'(TRIG_CYCLES - 1);
  localparam logic [15:0]        HOLD_LAST = 16'(HOLDOFF_CYCLES - 1);
  localparam logic [TIMER_W-1:0] TIMER_MAX = '1;

  state_t               state_q, state_d;
  logic [15:0]          cnt_q, cnt_d;
  logic [TIMER_W-1:0]   timer_q, timer_d;
  logic                 echo_prev_q;
  logic                 trig_q, trig_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 timeout_q, timeout_d;
  logic                 echo_rise;

  assign echo_rise = echo & ~echo_prev_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      timer_q     <= '0;
      echo_prev_q <= 1'b0;
      trig_q      <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      timer_q     <= timer_d;
      echo_prev_q <= echo;
      trig_q      <= trig_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      timeout_q   <= timeout_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    timer_d   = timer_q;
    done_d    = 1'b0;
    timeout_d = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_TRIG;
          cnt_d   = '0;
        end
      end

      S_TRIG: begin
        if (cnt_q == TRIG_LAST) begin
          state_d = S_LISTEN;
          cnt_d   = '0;
          timer_d = '0;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end

      // Echo edge takes priority over the max-count check so done wins a tie.
      S_LISTEN: begin
        if (echo_rise) begin
          done_d  = 1'b1;
          state_d = S_HOLDOFF;
          cnt_d   = '0;
        end else if (timer_q == TIMER_MAX) begin
          timeout_d = 1'b1;
          state_d   = S_HOLDOFF;
          cnt_d     = '0;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end

      S_HOLDOFF: begin
        if (cnt_q == HOLD_LAST) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end

      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase

    // Registered outputs are decoded from the next state so they line up with it.
    trig_d = (state_d == S_TRIG);
    busy_d = (state_d != S_IDLE);
  end

  assign trig    = trig_q;
  assign timer   = timer_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign timeout = timeout_q;

endmodule

// File: tb/tb_ultrasonic_ping_gen.sv
// Randomised and directed bench for ultrasonic_ping_gen against a timestamp-based ping model.
module tb_ultrasonic_ping_gen;

  localparam int unsigned TW   = 13;
  localparam int unsigned TC   = 4;
  localparam int unsigned HC   = 3;
  localparam int unsigned TMAX = (1 << TW) - 1;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic          echo = 1'b0;
  logic          trig, busy, done, timeout;
  logic [TW-1:0] timer;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  always #5 clk = ~clk;

  ultrasonic_ping_gen #(
    .TIMER_W(TW),
    .TRIG_CYCLES(TC),
    .HOLDOFF_CYCLES(HC)
  ) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .echo(echo),
    .trig(trig),
    .timer(timer),
    .busy(busy),
    .done(done),
    .timeout(timeout)
  );

  task automatic chk(input string name, input int unsigned act, input int unsigned exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
    end
  endtask

  // Ping model: each ping is described by its start edge and its end edge; outputs
  // after edge c follow from where c lies relative to those timestamps.
  int unsigned cyc = 0, k_start = 0, end_c = 0, lst = 0, held_timer = 0;
  bit          active = 0, ended = 0, end_done = 0, prev_echo = 0;
  bit          e_trig = 0, e_busy = 0, e_done = 0, e_timeout = 0;
  int unsigned e_timer = 0;

  initial forever begin
    @(posedge clk or posedge reset);
    if (reset) begin
      cyc = 0; active = 0; ended = 0; held_timer = 0; prev_echo = 0;
      e_trig = 0; e_busy = 0; e_done = 0; e_timeout = 0; e_timer = 0;
    end else begin
      cyc++;
      if (active && ended && cyc > end_c + HC) active = 0;
      if (!active && start) begin
        active  = 1;
        k_start = cyc;
        ended   = 0;
      end
      lst = k_start + TC;
      if (active && !ended && cyc > lst) begin
        if (echo && !prev_echo) begin
          ended = 1; end_c = cyc; end_done = 1;
        end else if (cyc - 1 - lst == TMAX) begin
          ended = 1; end_c = cyc; end_done = 0;
        end
      end
      prev_echo = echo;
      e_trig    = active && cyc < lst;
      e_busy    = active && !(ended && cyc >= end_c + HC);
      e_done    = active && ended && cyc == end_c && end_done;
      e_timeout = active && ended && cyc == end_c && !end_done;
      if (active && cyc >= lst) begin
        e_timer    = (ended && cyc >= end_c) ? end_c - 1 - lst : cyc - lst;
        held_timer = e_timer;
      end else begin
        e_timer = held_timer;
      end
    end
  end

  initial forever begin
    @(negedge clk);
    if (cmp_en && !reset) begin
      chk("m_trig", trig, e_trig);
      chk("m_busy", busy, e_busy);
      chk("m_done", done, e_done);
      chk("m_timeout", timeout, e_timeout);
      chk("m_timer", timer, e_timer);
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_listen();
    for (int i = 0; i < 100; i++) begin
      tick();
      if (!trig) return;
    end
    checks++;
    errors++;
    $display("FAIL listen_wait: got trig=%0d expected 0 within 100 cycles", trig);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; echo = 1'b0;
    #100;
    reset = 1'b0;
    #1;
    chk("rst_trig", trig, 0);
    chk("rst_timer", timer, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_timeout", timeout, 0);
    cmp_en = 1'b1;

    // Trigger width, listen count, echo capture, busy gating
    start = 1; tick(); start = 0;
    chk("trig_rise", trig, 1);
    chk("busy_rise", busy, 1);
    for (int i = 1; i < int'(TC); i++) begin
      if (i == 2) start = 1;
      tick(); start = 0;
      chk("trig_width", trig, 1);
    end
    tick();
    chk("trig_fall", trig, 0);
    chk("listen_entry_timer", timer, 0);
    for (int i = 1; i <= 9; i++) begin
      if (i == 5) start = 1;
      tick(); start = 0;
      chk("listen_count", timer, i);
    end
    echo = 1; tick();
    chk("echo_done", done, 1);
    chk("echo_timer", timer, 9);
    chk("echo_no_timeout", timeout, 0);
    start = 1; tick(); start = 0; echo = 0;
    chk("done_single", done, 0);
    chk("hold_timer", timer, 9);
    chk("hold_busy", busy, 1);
    tick();
    chk("hold_busy2", busy, 1);
    tick();
    chk("hold_end_busy", busy, 0);
    chk("hold_end_timer", timer, 9);
    tick();
    chk("no_queued_ping", trig, 0);

    // Echo already high at listen entry
    echo = 1; start = 1; tick(); start = 0;
    wait_listen();
    chk("prehigh_entry_done", done, 0);
    repeat (5) tick();
    chk("prehigh_t5", timer, 5);
    echo = 0;
    repeat (15) tick();
    chk("prehigh_t20", timer, 20);
    chk("prehigh_no_done", done, 0);
    echo = 1; tick();
    chk("prehigh_done", done, 1);
    chk("prehigh_timer", timer, 20);
    echo = 0;
    repeat (4) tick();

    // Timeout
    start = 1; tick(); start = 0;
    wait_listen();
    repeat (TMAX) tick();
    chk("to_max", timer, TMAX);
    chk("to_not_yet", timeout, 0);
    tick();
    chk("to_pulse", timeout, 1);
    chk("to_no_done", done, 0);
    chk("to_hold", timer, TMAX);
    tick();
    chk("to_single", timeout, 0);
    chk("to_hold2", timer, TMAX);
    repeat (3) tick();

    // Echo edge coinciding with timer max
    start = 1; tick(); start = 0;
    wait_listen();
    repeat (TMAX) tick();
    echo = 1; tick();
    chk("tie_done", done, 1);
    chk("tie_timeout", timeout, 0);
    chk("tie_timer", timer, TMAX);
    echo = 0;
    repeat (4) tick();

    // Asynchronous reset mid-trigger
    start = 1; tick(); start = 0;
    tick();
    chk("pre_rst_trig", trig, 1);
    #1 reset = 1;
    #1;
    chk("async_rst_trig", trig, 0);
    chk("async_rst_busy", busy, 0);
    chk("async_rst_timer", timer, 0);
    @(negedge clk);
    #1 reset = 0;

    // Start held high re-arms on the first idle edge
    start = 1; tick();
    wait_listen();
    repeat (2) tick();
    echo = 1; tick();
    chk("held_done", done, 1);
    echo = 0;
    repeat (3) tick();
    chk("held_idle_busy", busy, 0);
    chk("held_idle_trig", trig, 0);
    tick();
    chk("held_rearm_trig", trig, 1);
    chk("held_rearm_busy", busy, 1);
    start = 0;

    // Randomised traffic
    repeat (4000) begin
      start = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 7) == 0) echo = ~echo;
      tick();
    end
    start = 0;
    echo  = 0;
    repeat (20) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
